arb_requester: RTL and testbench

- Client-side counterpart of the shared req/gnt arbiter: one instance per arbiter channel.
- Buffers packets from a local stream and raises req only once a complete packet is stored (store-and-forward), so a grant is never idle.
- When granted, drains exactly one packet onto the shared bus, drops req after the last beat, then enforces a quiet gap so the arbiter sees a clean release.

---
 rtl/arb_pkg.sv | 19 +
 rtl/sync_fifo.sv | 59 +++++
 rtl/arb_requester.sv | 143 ++++++++++++++
 tb/tb_arb_requester.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the arbiter-client requester.
//   state_t : requester FSM state, 2-bit encoding
//             IDLE - waiting for a complete packet (or a full FIFO)
//             REQ  - req raised, waiting for the first sampled gnt
//             XFER - draining exactly one packet onto the shared bus
//             GAP  - req released, quiet time before the next request
// -----------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// rdata whenever empty is low; pop advances to the next entry.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
// Ports:
//   clk, rst     clock, synchronous active-high reset (empties the FIFO)
//   push, wdata  write request and data (ignored while full)
//   pop          read request (ignored while empty)
//   rdata        head entry (valid while !empty)
//   full, empty  status flags
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/arb_requester.sv
// -----------------------------------------------------------------------------
// arb_requester
// Client side of a shared req/gnt arbiter channel. Upstream beats are
// buffered; req is raised only once a whole packet is stored (or the FIFO is
// full, as a cut-through fallback for packets longer than DEPTH). On grant,
// exactly one packet is drained, req is dropped after its last beat and a
// quiet gap is enforced before the next request.
//
// Handshakes: a beat moves on a channel in any cycle where valid and ready
// are both high at the rising clock edge; valid never depends on ready, and
// while valid is high without ready the beat (data/last) is held stable.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_last     upstream stream
//   req                       registered request to the arbiter
//   gnt                       grant from the arbiter
//   out_valid/out_ready/out_data/out_last shared-bus stream
//   grant_lost                sticky: gnt fell mid-packet (cleared by rst)
//   state_dbg, pkt_cnt_dbg    FSM state and buffered complete-packet count
// -----------------------------------------------------------------------------
module arb_requester
    import arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_last,
    output logic                   req,
    input  logic                   gnt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_last,
    output logic                   grant_lost,
    output state_t                 state_dbg,
    output logic [$clog2(DEPTH):0] pkt_cnt_dbg
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

    state_t            state;
    logic [CW-1:0]     pkt_cnt;
    logic [GW-1:0]     gap_cnt;

    logic [DATA_W:0]   fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              head_last;
    logic [DATA_W-1:0] head_data;

    assign in_ready  = !fifo_full;
    assign push      = in_valid && !fifo_full;
    assign head_last = fifo_rdata[DATA_W];
    assign head_data = fifo_rdata[DATA_W-1:0];

    // A beat is offered only while we own the bus; an empty FIFO mid-packet
    // (cut-through) or a withdrawn grant simply stalls with req still held.
    assign out_valid = (state == XFER) && gnt && !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? head_data : '0;
    assign out_last  = out_valid && head_last;

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata ({in_last, in_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Count of complete packets held in the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else begin
            case ({push && in_last, pop && head_last})
                2'b10:   pkt_cnt <= pkt_cnt + CW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - CW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // req is set/cleared together with the state so it comes straight from
    // a flop. The GAP countdown plus the IDLE evaluation cycle keeps req low
    // for GAP_CYCLES+1 cycles, covering the arbiter's lagged release detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req        <= 1'b0;
            gap_cnt    <= '0;
            grant_lost <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pkt_cnt != '0 || fifo_full) begin
                        state <= REQ;
                        req   <= 1'b1;
                    end
                end
                REQ: begin
                    if (gnt) state <= XFER;
                end
                XFER: begin
                    // While in XFER the last beat has not yet gone, so any
                    // low gnt here is a grant lost mid-packet.
                    if (!gnt) grant_lost <= 1'b1;
                    if (pop && head_last) begin
                        state   <= GAP;
                        req     <= 1'b0;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - GW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign state_dbg   = state;
    assign pkt_cnt_dbg = pkt_cnt;

endmodule

// File: tb/tb_arb_requester.sv
// -----------------------------------------------------------------------------
// tb_arb_requester
// Bench for arb_requester. Upstream beats, arbiter grants and bus ready are
// driven by tasks/processes; a monitor on the falling edge keeps a
// behavioural model (beat queue, occupancy, complete-packet count, transfer
// flag) and compares the DUT against it every cycle.
// -----------------------------------------------------------------------------
module tb_arb_requester;
    import arb_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int GAP   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          req;
    logic          gnt;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          grant_lost;
    state_t        state_dbg;
    logic [$clog2(DEPTH):0] pkt_cnt_dbg;

    arb_requester #(
        .DATA_W     (DW),
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .req         (req),
        .gnt         (gnt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .grant_lost  (grant_lost),
        .state_dbg   (state_dbg),
        .pkt_cnt_dbg (pkt_cnt_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / checker ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- stimulus controls ----------------
    int gnt_delay = 1;   // cycles after req before gnt rises (>=1)
    bit hold_gnt  = 0;   // keep gnt high regardless of req
    int drop_at   = 0;   // drop gnt for 2 cycles after this many beats (0=off)
    int rdy_mode  = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
    int max_gap   = 0;   // max idle cycles between upstream beats

    // ---------------- reference model state ----------------
    logic [DW:0] exp_q[$];      // {last, data} beats accepted, not yet sent
    int  occ       = 0;         // FIFO occupancy
    int  pkts      = 0;         // complete packets buffered
    bit  xfer      = 0;         // we own the bus for the current packet
    bit  exp_gl    = 0;         // expected sticky grant_lost
    int  beats_done = 0;        // beats sent of the current packet
    int  pops_total = 0;
    int  low_run   = 100;       // consecutive cycles with req low
    bit  req_prev  = 0;
    bit  cond_prev = 0;         // previous cycle: a packet or a full FIFO waiting
    bit  last_pop_prev = 0;
    bit  stall_prev = 0;
    logic [DW:0] held;

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                occ = 0; pkts = 0; xfer = 0; exp_gl = 0; beats_done = 0;
                low_run = 100; req_prev = 0; cond_prev = 0;
                last_pop_prev = 0; stall_prev = 0;
            end else begin
                logic cond_now;
                bit   pop_last;
                check("in_ready", in_ready, occ < DEPTH);
                check("pkt_cnt", pkt_cnt_dbg, pkts);
                check("grant_lost", grant_lost, exp_gl);
                check("out_valid", out_valid, xfer && gnt && occ > 0);
                check("state_xfer", state_dbg == XFER, xfer);
                if (req && !req_prev) begin
                    check("req_low_gap", low_run >= GAP + 1, 1);
                    check("req_cause", cond_prev, 1);
                end
                if (last_pop_prev) check("req_drop", req, 0);
                if (stall_prev) check("hold", {out_valid, out_last, out_data}, {1'b1, held});

                cond_now = (pkts > 0) || (occ == DEPTH);
                pop_last = 0;
                if (out_valid && out_ready) begin
                    check("q_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        check("beat", {out_last, out_data}, exp_q[0]);
                        void'(exp_q.pop_front());
                    end
                    occ--; pops_total++; beats_done++;
                    if (out_last) begin
                        pkts--; pop_last = 1; beats_done = 0;
                    end
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back({in_last, in_data});
                    occ++;
                    if (in_last) pkts++;
                end
                if (xfer && !gnt) exp_gl = 1;
                if (pop_last) xfer = 0;
                else if (req && gnt && !xfer) xfer = 1;

                cond_prev     = cond_now;
                last_pop_prev = pop_last;
                stall_prev    = out_valid && !out_ready;
                held          = {out_last, out_data};
                low_run       = req ? 0 : low_run + 1;
                req_prev      = req;
            end
        end
    end

    // ---------------- arbiter model ----------------
    initial begin
        int  wait_cnt  = 0;
        int  drop_left = 0;
        bit  drop_done = 0;
        gnt = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (hold_gnt) begin
                gnt = 1'b1;
            end else if (!req) begin
                gnt = 1'b0; wait_cnt = 0; drop_left = 0; drop_done = 0;
            end else if (gnt && drop_at != 0 && !drop_done && beats_done == drop_at) begin
                gnt = 1'b0; drop_left = 1; drop_done = 1;
            end else if (drop_left > 0) begin
                drop_left--;
            end else if (!gnt) begin
                wait_cnt++;
                if (wait_cnt > gnt_delay || drop_done) gnt = 1'b1;
            end
        end
    end

    // ---------------- bus ready driver ----------------
    initial begin
        int idx = 0;
        logic [3:0] pat;
        pat = 4'b1001;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1:       begin out_ready = pat[3 - (idx % 4)]; idx++; end
                2:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b1;
            endcase
        end
    end

    // ---------------- upstream driver tasks ----------------
    task automatic push_beat(input logic [DW-1:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 3000) break;
        end
        check("push_timeout", n <= 3000, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic send_pkt(input int len);
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
            push_beat($urandom, i == len - 1);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while ((exp_q.size() != 0 || req) && n < 5000);
        check("drain_timeout", n < 5000, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base;
        int n;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_grant_lost", grant_lost, 0);
        check("rst_state", state_dbg, IDLE);
        check("rst_pkt_cnt", pkt_cnt_dbg, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;

        // single 3-beat packet, grant 1 cycle after req
        base = pops_total;
        send_pkt(3);
        wait_drain();
        check("t1_beats", pops_total - base, 3);

        // two 2-beat packets with gnt held high throughout
        hold_gnt = 1;
        base = pops_total;
        send_pkt(2);
        send_pkt(2);
        wait_drain();
        hold_gnt = 0;
        check("t2_beats", pops_total - base, 4);

        // 20-beat packet longer than the FIFO, grant delayed 5 cycles
        gnt_delay = 5; max_gap = 2;
        base = pops_total;
        send_pkt(20);
        wait_drain();
        check("t3_beats", pops_total - base, 20);
        gnt_delay = 1; max_gap = 0;

        // bus ready pattern 1,0,0,1 during a 4-beat transfer
        rdy_mode = 1;
        base = pops_total;
        send_pkt(4);
        wait_drain();
        check("t4_beats", pops_total - base, 4);
        rdy_mode = 0;

        // gnt withdrawn for 2 cycles after beat 1
        drop_at = 1;
        base = pops_total;
        send_pkt(4);
        wait_drain();
        check("t5_beats", pops_total - base, 4);
        check("t5_grant_lost", grant_lost, 1);
        drop_at = 0;

        // reset in the middle of a 4-beat transfer after beat 2
        send_pkt(4);
        n = 0;
        while (beats_done < 2 && n < 500) begin @(posedge clk); #1; n++; end
        check("t6_reach_beat2", beats_done, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_req", req, 0);
        check("t6_out_valid", out_valid, 0);
        check("t6_pkt_cnt", pkt_cnt_dbg, 0);
        check("t6_grant_lost", grant_lost, 0);
        check("t6_state", state_dbg, IDLE);
        check("t6_in_ready", in_ready, 1);
        repeat (4) @(posedge clk);
        check("t6_stays_idle", state_dbg, IDLE);
        @(posedge clk); #1;

        // randomized traffic
        rdy_mode = 2; max_gap = 2;
        base = pops_total;
        n = 0;
        for (int p = 0; p < 12; p++) begin
            int len;
            len = $urandom_range(1, 6);
            n += len;
            gnt_delay = $urandom_range(1, 4);
            send_pkt(len);
        end
        wait_drain();
        check("t7_beats", pops_total - base, n);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
